// File: rtl/seg7_pkg.sv
// Shared types, segment patterns and anode helpers for the seven-segment scan driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } digit_idx_t;

    typedef logic [3:0] bcd_t;

    // Active-low segments, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        logic [3:0] an;
        an = ANODE_OFF;
        case (idx)
            D0: an = 4'b1110;
            D1: an = 4'b1101;
            D2: an = 4'b1011;
            D3: an = 4'b0111;
            default: an = ANODE_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; invalid codes show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Four-digit common-anode scan driver with per-frame digit snapshot.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int TICK_DIV = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] HEX_display_digits,
    input  logic        display_en,
    output logic [3:0]  anode_bits,
    output logic [6:0]  seven_segments_LED_output,
    output logic [3:0]  LED_binary_coded_decimal,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] presc_q, presc_d;
    digit_idx_t       idx_q, idx_d;
    logic [15:0]      snap_q, snap_d;
    logic [3:0]       anode_q, anode_d;
    logic [6:0]       seg_q, seg_d;
    bcd_t             bcd_q, bcd_d;
    logic             frame_tick_q, frame_tick_d;

    logic             slot_tick;
    bcd_t             sel_bcd;
    logic [6:0]       sel_seg;
    logic             blank;

    bcd_to_seg7 u_dec (
        .bcd_i (sel_bcd),
        .seg_o (sel_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            idx_q        <= D0;
            snap_q       <= '0;
            anode_q      <= ANODE_OFF;
            seg_q        <= SEG_OFF;
            bcd_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            bcd_q        <= bcd_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        slot_tick = (presc_q == CNT_W'(TICK_DIV - 1));
        presc_d   = slot_tick ? '0 : presc_q + CNT_W'(1);

        idx_d = idx_q;
        if (slot_tick) begin
            case (idx_q)
                D0: idx_d = D1;
                D1: idx_d = D2;
                D2: idx_d = D3;
                D3: idx_d = D0;
                default: idx_d = D0;
            endcase
        end

        // Snapshot only at the frame boundary so a mid-frame carry cannot tear the display.
        snap_d       = snap_q;
        frame_tick_d = 1'b0;
        if (slot_tick && idx_q == D3) begin
            snap_d       = HEX_display_digits;
            frame_tick_d = 1'b1;
        end
    end

    always_comb begin
        sel_bcd = '0;
        case (idx_q)
            D0: sel_bcd = snap_q[3:0];
            D1: sel_bcd = snap_q[7:4];
            D2: sel_bcd = snap_q[11:8];
            D3: sel_bcd = snap_q[15:12];
            default: sel_bcd = '0;
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        blank = ((idx_q == D3) && (snap_q[15:12] == 4'd0)) ||
                ((idx_q == D2) && (snap_q[15:8]  == 8'd0)) ||
                ((idx_q == D1) && (snap_q[15:4]  == 12'd0));
`else
        blank = 1'b0;
`endif

        anode_d = display_en ? anode_for(idx_q) : ANODE_OFF;
        seg_d   = sel_seg;
        bcd_d   = sel_bcd;
        if (blank) begin
            anode_d = ANODE_OFF;
            seg_d   = SEG_OFF;
        end
    end

    assign anode_bits                = anode_q;
    assign seven_segments_LED_output = seg_q;
    assign LED_binary_coded_decimal  = bcd_q;
    assign frame_tick                = frame_tick_q;

endmodule
